blvds_frame_rx: RTL

//  Receiver for the 18-bit BLVDS frame stream produced by the frame generator (user_bcvs side).

---
 rtl/blvds_frame_rx.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/blvds_frame_rx.sv
// BLVDS frame receiver: parses the 9-word header, unpacks {Im,Re} samples and
// verifies the trailing 16-bit additive checksum of each frame.
module blvds_frame_rx #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             iclk,
    input  logic             ireset,
    input  logic [17:0]      iDATA_BLVDS,
    output logic [31:0]      oSAMPLE,
    output logic             oSAMPLE_VLD,
    output logic [15:0]      oSAMPLE_IDX,
    output logic [7:0]       oNUM_PACK,
    output logic [7:0]       oSIZE_PACK,
    output logic [15:0]      oNUM_OI,
    output logic [15:0]      oNUM_TIR,
    output logic [15:0]      oBCUR,
    output logic [15:0]      oICUR,
    output logic [31:0]      oLPPS,
    output logic [31:0]      oARUSH,
    output logic             oHDR_VLD,
    output logic             oFRAME_DONE,
    output logic             oCSUM_ERR,
    output logic             oERR_SOF,
    output logic             oERR_TO,
    output logic             oBUSY,
    output logic [CNT_W-1:0] oFRAME_CNT
);

    localparam int unsigned ToW = $clog2(TIMEOUT + 1);
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StHdr, StData, StCsum} state_e;

    state_e r_state, w_state_next;

    logic        w_vld, w_sof;
    logic [15:0] w_word;
    logic        w_start, w_err_sof, w_take_hdr, w_take_dat, w_take_csm, w_hdr_done, w_to_hit;
    logic [15:0] w_prod;

    logic [ToW-1:0]   r_to_cnt;
    logic [3:0]       r_hdr_cnt;
    logic [15:0]      r_csum;
    logic [7:0]       r_sh_num_pack, r_sh_size_pack;
    logic [15:0]      r_sh_num_oi, r_sh_num_tir, r_sh_bcur;
    logic [31:0]      r_sh_lpps, r_sh_arush;
    logic [15:0]      r_samp_cnt, r_samp_last, r_im;
    logic             r_phase;
    logic [31:0]      r_sample;
    logic             r_sample_vld;
    logic [15:0]      r_sample_idx;
    logic [7:0]       r_num_pack, r_size_pack;
    logic [15:0]      r_num_oi, r_num_tir, r_bcur, r_icur;
    logic [31:0]      r_lpps, r_arush;
    logic             r_hdr_vld, r_frame_done, r_csum_err, r_err_sof, r_err_to;
    logic [CNT_W-1:0] r_frame_cnt;

    assign w_vld  = iDATA_BLVDS[17];
    assign w_sof  = iDATA_BLVDS[16];
    assign w_word = iDATA_BLVDS[15:0];
    assign w_prod = 16'(r_sh_num_pack) * 16'(r_sh_size_pack);

    always_ff @(posedge iclk) begin
        if (ireset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A valid SOF word always (re)starts a frame, whatever state we are in.
    always_comb begin
        w_state_next = r_state;
        if (w_vld && w_sof) begin
            w_state_next = StHdr;
        end else if (w_to_hit) begin
            w_state_next = StIdle;
        end else if (w_vld) begin
            case (r_state)
                StHdr: begin
                    if (r_hdr_cnt == 4'd8) begin
                        w_state_next = (w_prod == 16'd0) ? StCsum : StData;
                    end
                end
                StData: begin
                    if (r_phase && (r_samp_cnt == r_samp_last)) begin
                        w_state_next = StCsum;
                    end
                end
                StCsum:  w_state_next = StIdle;
                default: w_state_next = r_state;
            endcase
        end
    end

    always_comb begin
        w_start    = w_vld && w_sof;
        w_err_sof  = w_start && (r_state != StIdle);
        w_take_hdr = w_vld && !w_sof && (r_state == StHdr);
        w_take_dat = w_vld && !w_sof && (r_state == StData);
        w_take_csm = w_vld && !w_sof && (r_state == StCsum);
        w_hdr_done = w_take_hdr && (r_hdr_cnt == 4'd8);
        w_to_hit   = (r_state != StIdle) && !w_vld && (r_to_cnt == ToLast);
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            r_to_cnt       <= '0;
            r_hdr_cnt      <= '0;
            r_csum         <= '0;
            r_sh_num_pack  <= '0;
            r_sh_size_pack <= '0;
            r_sh_num_oi    <= '0;
            r_sh_num_tir   <= '0;
            r_sh_bcur      <= '0;
            r_sh_lpps      <= '0;
            r_sh_arush     <= '0;
            r_samp_cnt     <= '0;
            r_samp_last    <= '0;
            r_im           <= '0;
            r_phase        <= 1'b0;
            r_sample       <= '0;
            r_sample_vld   <= 1'b0;
            r_sample_idx   <= '0;
            r_num_pack     <= '0;
            r_size_pack    <= '0;
            r_num_oi       <= '0;
            r_num_tir      <= '0;
            r_bcur         <= '0;
            r_icur         <= '0;
            r_lpps         <= '0;
            r_arush        <= '0;
            r_hdr_vld      <= 1'b0;
            r_frame_done   <= 1'b0;
            r_csum_err     <= 1'b0;
            r_err_sof      <= 1'b0;
            r_err_to       <= 1'b0;
            r_frame_cnt    <= '0;
        end else begin
            r_sample_vld <= 1'b0;
            r_hdr_vld    <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_sof    <= w_err_sof;
            r_err_to     <= w_to_hit;

            if ((r_state == StIdle) || w_vld || w_to_hit) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + ToW'(1);
            end

            if (w_start) begin
                r_csum         <= w_word;
                r_hdr_cnt      <= 4'd1;
                r_sh_num_pack  <= w_word[15:8];
                r_sh_size_pack <= w_word[7:0];
            end

            if (w_take_hdr) begin
                r_csum    <= r_csum + w_word;
                r_hdr_cnt <= r_hdr_cnt + 4'd1;
                case (r_hdr_cnt)
                    4'd1:    r_sh_num_oi        <= w_word;
                    4'd2:    r_sh_num_tir       <= w_word;
                    4'd3:    r_sh_lpps[31:16]   <= w_word;
                    4'd4:    r_sh_lpps[15:0]    <= w_word;
                    4'd5:    r_sh_arush[31:16]  <= w_word;
                    4'd6:    r_sh_arush[15:0]   <= w_word;
                    4'd7:    r_sh_bcur          <= w_word;
                    default: r_hdr_cnt          <= r_hdr_cnt + 4'd1;
                endcase
            end

            // Shadowed fields reach the outputs together, with Icur taken straight off the wire.
            if (w_hdr_done) begin
                r_num_pack  <= r_sh_num_pack;
                r_size_pack <= r_sh_size_pack;
                r_num_oi    <= r_sh_num_oi;
                r_num_tir   <= r_sh_num_tir;
                r_lpps      <= r_sh_lpps;
                r_arush     <= r_sh_arush;
                r_bcur      <= r_sh_bcur;
                r_icur      <= w_word;
                r_hdr_vld   <= 1'b1;
                r_samp_cnt  <= '0;
                r_samp_last <= w_prod - 16'd1;
                r_phase     <= 1'b0;
            end

            if (w_take_dat) begin
                r_csum <= r_csum + w_word;
                if (!r_phase) begin
                    r_im    <= w_word;
                    r_phase <= 1'b1;
                end else begin
                    r_sample     <= {r_im, w_word};
                    r_sample_vld <= 1'b1;
                    r_sample_idx <= r_samp_cnt;
                    r_samp_cnt   <= r_samp_cnt + 16'd1;
                    r_phase      <= 1'b0;
                end
            end

            if (w_take_csm) begin
                r_frame_done <= 1'b1;
                r_csum_err   <= (w_word != r_csum);
                if (w_word == r_csum) begin
                    r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign oSAMPLE     = r_sample;
    assign oSAMPLE_VLD = r_sample_vld;
    assign oSAMPLE_IDX = r_sample_idx;
    assign oNUM_PACK   = r_num_pack;
    assign oSIZE_PACK  = r_size_pack;
    assign oNUM_OI     = r_num_oi;
    assign oNUM_TIR    = r_num_tir;
    assign oBCUR       = r_bcur;
    assign oICUR       = r_icur;
    assign oLPPS       = r_lpps;
    assign oARUSH      = r_arush;
    assign oHDR_VLD    = r_hdr_vld;
    assign oFRAME_DONE = r_frame_done;
    assign oCSUM_ERR   = r_csum_err;
    assign oERR_SOF    = r_err_sof;
    assign oERR_TO     = r_err_to;
    assign oBUSY       = (r_state != StIdle);
    assign oFRAME_CNT  = r_frame_cnt;

endmodule
